// File: rtl/pht_access_scheduler_pkg.sv
// Shared PHT scheduler types: index/counter paths, FSM states, update-queue entry, saturating counter helper.
// No logic here; depth and thresholds are tuned in this one place.
package pht_access_scheduler_pkg;

    localparam int CONF_PHT_ENTRY_NUM          = 64;
    localparam int PHT_ENTRY_NUM               = CONF_PHT_ENTRY_NUM;
    localparam int PHT_ENTRY_NUM_BIT_WIDTH     = $clog2(PHT_ENTRY_NUM);
    localparam int PHT_QUEUE_SIZE              = 32;
    localparam int PHT_QUEUE_SIZE_BIT_WIDTH    = $clog2(PHT_QUEUE_SIZE);
    localparam int PHT_DRAIN_THRESHOLD         = 24;

    typedef logic [PHT_ENTRY_NUM_BIT_WIDTH-1:0]  PHT_IndexPath;
    typedef logic [1:0]                          PHT_EntryPath;
    typedef logic [PHT_QUEUE_SIZE_BIT_WIDTH-1:0] PhtQueuePtr;
    typedef logic [PHT_QUEUE_SIZE_BIT_WIDTH:0]   PhtQueueCount;

    localparam PHT_EntryPath PHT_INIT_VALUE = 2'b10;

    typedef enum logic {
        PHT_SCHED_INIT,
        PHT_SCHED_RUN
    } PhtAccessSchedState;

    typedef struct packed {
        PHT_IndexPath index;
        PHT_EntryPath value;
    } PhtUpdateQueueEntry;

    function automatic PHT_EntryPath PhtNextValue(input PHT_EntryPath prev, input logic taken);
        if (taken) begin
            return (prev == 2'b11) ? prev : prev + 2'd1;
        end
        return (prev == 2'b00) ? prev : prev - 2'd1;
    endfunction

endpackage

// File: rtl/pht_update_queue.sv
// Circular FIFO of pending PHT counter writes; pop reads the head combinationally, push lands next edge.
// Caller must not push when full unless popping the same cycle. RSD_PHT_UPDATE_BYPASS_EN exposes contents.
module pht_update_queue
    import pht_access_scheduler_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_push,
    input  PhtUpdateQueueEntry i_push_dat,
    input  logic               i_pop,
    output PhtUpdateQueueEntry o_head_dat,
    output PhtQueueCount       o_count,
    output logic               o_full,
    output logic               o_empty
`ifdef RSD_PHT_UPDATE_BYPASS_EN
    ,
    output PhtUpdateQueueEntry [PHT_QUEUE_SIZE-1:0] o_entries,
    output logic [PHT_QUEUE_SIZE-1:0]               o_valid,
    output PhtQueuePtr                              o_head_ptr
`endif
);

    PhtUpdateQueueEntry r_mem [PHT_QUEUE_SIZE];
    PhtQueuePtr         r_head;
    PhtQueuePtr         r_tail;
    PhtQueueCount       r_count;

    assign o_head_dat = r_mem[r_head];
    assign o_count    = r_count;
    assign o_full     = (r_count == PhtQueueCount'(PHT_QUEUE_SIZE));
    assign o_empty    = (r_count == '0);

    // When full, tail aliases head: the head is read this cycle and overwritten at the edge.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_tail] <= i_push_dat;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (i_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef RSD_PHT_UPDATE_BYPASS_EN
    assign o_head_ptr = r_head;

    always_comb begin
        o_entries = '0;
        o_valid   = '0;
        for (int j = 0; j < PHT_QUEUE_SIZE; j++) begin
            o_entries[j] = r_mem[j];
            o_valid[j]   = ({1'b0, PhtQueuePtr'(PhtQueuePtr'(j) - r_head)} < r_count);
        end
    end
`endif

endmodule

// File: rtl/pht_access_scheduler.sv
// Owns the PHT RAM port: init sweep after reset, then arbitrates fetch lookups against queued counter writes.
// Lookup data one cycle after grant; lookups stall once the queue crosses the drain threshold. RSD_PHT_UPDATE_BYPASS_EN forwards queued values.
module pht_access_scheduler
    import pht_access_scheduler_pkg::*;
(
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                lookupReq,
    input  logic [PHT_ENTRY_NUM_BIT_WIDTH-1:0]  lookupIndex,
    output logic                                lookupGrant,
    output logic                                lookupRespValid,
    output logic [1:0]                          lookupRespValue,
    input  logic                                updateValid,
    input  logic                                updateIsCondBr,
    input  logic [PHT_ENTRY_NUM_BIT_WIDTH-1:0]  updateIndex,
    input  logic                                updateTaken,
    input  logic [1:0]                          updatePrevValue,
    output logic [PHT_ENTRY_NUM_BIT_WIDTH-1:0]  ramAddr,
    output logic                                ramWE,
    output logic [1:0]                          ramWV,
    input  logic [1:0]                          ramRV,
    output logic                                initBusy,
    output logic [PHT_QUEUE_SIZE_BIT_WIDTH:0]   queueCount,
    output logic                                droppedUpdate
);

    PhtAccessSchedState r_state, w_state_nxt;
    PHT_IndexPath       r_sweep;
    logic               r_resp_valid;
    PHT_EntryPath       r_resp_hold;
    logic               r_drop;

    logic               w_upd, w_push, w_pop, w_drop, w_full, w_empty;
    PhtQueueCount       w_count;
    PhtUpdateQueueEntry w_head, w_new_entry;
    PHT_EntryPath       w_resp_now;

    assign w_upd       = updateValid && updateIsCondBr;
    assign w_drop      = w_upd && (r_state == PHT_SCHED_INIT) && w_full;
    assign w_push      = w_upd && !w_drop;
    assign w_new_entry = '{index: updateIndex, value: PhtNextValue(updatePrevValue, updateTaken)};

`ifdef RSD_PHT_UPDATE_BYPASS_EN
    PhtUpdateQueueEntry [PHT_QUEUE_SIZE-1:0] w_q_entries;
    logic [PHT_QUEUE_SIZE-1:0]               w_q_valid;
    PhtQueuePtr                              w_q_head;
    logic                                    w_byp_hit;
    PHT_EntryPath                            w_byp_val;
    logic                                    r_byp_hit;
    PHT_EntryPath                            r_byp_val;
`endif

    pht_update_queue u_queue (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_push     (w_push),
        .i_push_dat (w_new_entry),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_count    (w_count),
        .o_full     (w_full),
        .o_empty    (w_empty)
`ifdef RSD_PHT_UPDATE_BYPASS_EN
        ,
        .o_entries  (w_q_entries),
        .o_valid    (w_q_valid),
        .o_head_ptr (w_q_head)
`endif
    );

    always_comb begin
        w_state_nxt = r_state;
        ramAddr     = lookupIndex;
        ramWE       = 1'b0;
        ramWV       = w_head.value;
        lookupGrant = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            PHT_SCHED_INIT: begin
                ramWE   = 1'b1;
                ramAddr = r_sweep;
                ramWV   = PHT_INIT_VALUE;
                if (r_sweep == PHT_IndexPath'(PHT_ENTRY_NUM - 1)) begin
                    w_state_nxt = PHT_SCHED_RUN;
                end
            end
            PHT_SCHED_RUN: begin
                // A full queue always drains, which is what makes a push at full safe in RUN.
                if (!w_empty && (!lookupReq || w_full ||
                                 w_count >= PhtQueueCount'(PHT_DRAIN_THRESHOLD))) begin
                    ramWE   = 1'b1;
                    ramAddr = w_head.index;
                    w_pop   = 1'b1;
                end else if (lookupReq) begin
                    lookupGrant = 1'b1;
                end
            end
            default: w_state_nxt = PHT_SCHED_INIT;
        endcase
        if (rst) begin
            ramWE = 1'b0;
        end
    end

`ifdef RSD_PHT_UPDATE_BYPASS_EN
    // Oldest-to-newest walk from head so the last match is the newest queued value.
    always_comb begin
        w_byp_hit = 1'b0;
        w_byp_val = '0;
        for (int i = 0; i < PHT_QUEUE_SIZE; i++) begin
            if (w_q_valid[PhtQueuePtr'(w_q_head + PhtQueuePtr'(i))] &&
                w_q_entries[PhtQueuePtr'(w_q_head + PhtQueuePtr'(i))].index == lookupIndex) begin
                w_byp_hit = 1'b1;
                w_byp_val = w_q_entries[PhtQueuePtr'(w_q_head + PhtQueuePtr'(i))].value;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byp_hit <= 1'b0;
            r_byp_val <= '0;
        end else begin
            r_byp_hit <= lookupGrant && w_byp_hit;
            r_byp_val <= w_byp_val;
        end
    end

    assign w_resp_now = r_byp_hit ? r_byp_val : ramRV;
`else
    assign w_resp_now = ramRV;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= PHT_SCHED_INIT;
            r_sweep      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_hold  <= '0;
            r_drop       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_resp_valid <= lookupGrant;
            r_drop       <= w_drop;
            if (r_state == PHT_SCHED_INIT) begin
                r_sweep <= r_sweep + 1'b1;
            end
            if (r_resp_valid) begin
                r_resp_hold <= w_resp_now;
            end
        end
    end

    assign lookupRespValid = r_resp_valid;
    assign lookupRespValue = r_resp_valid ? w_resp_now : r_resp_hold;
    assign initBusy        = (r_state == PHT_SCHED_INIT);
    assign queueCount      = w_count;
    assign droppedUpdate   = r_drop;

endmodule

// File: tb/tb_pht_access_scheduler.sv
// Directed bench for pht_access_scheduler with a RAM model and write/response scoreboards.
// Honours RSD_PHT_UPDATE_BYPASS_EN when choosing expected lookup data.
module tb_pht_access_scheduler;

    localparam int N      = 64;
    localparam int QSIZE  = 32;
    localparam int THRESH = 24;
`ifdef RSD_PHT_UPDATE_BYPASS_EN
    localparam logic [1:0] IDX7_EXP = 2'd3;
`else
    localparam logic [1:0] IDX7_EXP = 2'd2;
`endif

    typedef struct packed {
        logic [5:0] idx;
        logic [1:0] val;
    } wr_t;

    logic       clk, rst;
    logic       lookupReq, lookupGrant, lookupRespValid;
    logic [5:0] lookupIndex;
    logic [1:0] lookupRespValue;
    logic       updateValid, updateIsCondBr, updateTaken;
    logic [5:0] updateIndex;
    logic [1:0] updatePrevValue;
    logic [5:0] ramAddr;
    logic       ramWE;
    logic [1:0] ramWV, ramRV;
    logic       initBusy, droppedUpdate;
    logic [5:0] queueCount;

    int vectors = 0;
    int miscompares = 0;

    pht_access_scheduler dut (
        .clk(clk), .rst(rst),
        .lookupReq(lookupReq), .lookupIndex(lookupIndex), .lookupGrant(lookupGrant),
        .lookupRespValid(lookupRespValid), .lookupRespValue(lookupRespValue),
        .updateValid(updateValid), .updateIsCondBr(updateIsCondBr), .updateIndex(updateIndex),
        .updateTaken(updateTaken), .updatePrevValue(updatePrevValue),
        .ramAddr(ramAddr), .ramWE(ramWE), .ramWV(ramWV), .ramRV(ramRV),
        .initBusy(initBusy), .queueCount(queueCount), .droppedUpdate(droppedUpdate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first single-port RAM.
    logic [1:0] mem [N];
    initial begin
        for (int k = 0; k < N; k++) mem[k] = 2'd0;
        ramRV = 2'd0;
    end
    always @(posedge clk) begin
        if (ramWE) mem[ramAddr] <= ramWV;
        ramRV <= mem[ramAddr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] sat_next(input logic [1:0] prev, input logic taken);
        int p;
        p = int'(prev) + (taken ? 1 : -1);
        if (p > 3) p = 3;
        if (p < 0) p = 0;
        return p[1:0];
    endfunction

    wr_t        exp_wr [$];
    logic [1:0] exp_rsp [$];
    int         sweep = 0;
    int         drops_seen = 0;
    logic       cur_init = 1'b1;
    logic       exp_drop = 1'b0;
    logic       drop_now;
    logic       we_exp;
    wr_t        w_pop;
    logic [1:0] r_pop;

    function automatic logic [1:0] rsp_model(input logic [5:0] idx);
        logic [1:0] v;
        v = mem[idx];
`ifdef RSD_PHT_UPDATE_BYPASS_EN
        foreach (exp_wr[k]) if (exp_wr[k].idx == idx) v = exp_wr[k].val;
`endif
        return v;
    endfunction

    // Scoreboard push: an accepted update becomes an expected RAM write.
    always @(posedge clk) begin
        if (!rst) begin
            drop_now = 1'b0;
            if (updateValid && updateIsCondBr) begin
                if (cur_init && exp_wr.size() == QSIZE) drop_now = 1'b1;
                else exp_wr.push_back('{idx: updateIndex, val: sat_next(updatePrevValue, updateTaken)});
            end
            exp_drop = drop_now;
        end
    end

    // Scoreboard pop/compare, once per cycle away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_wr.delete();
            exp_rsp.delete();
            sweep    = 0;
            cur_init = 1'b1;
            exp_drop = 1'b0;
        end else begin
            cur_init = (sweep < N);
            check("initBusy", initBusy, cur_init);
            check("queueCount", queueCount, exp_wr.size());
            check("droppedUpdate", droppedUpdate, exp_drop);
            if (droppedUpdate) drops_seen++;
            check("lookupRespValid", lookupRespValid, exp_rsp.size() != 0);
            if (lookupRespValid && exp_rsp.size() != 0) begin
                r_pop = exp_rsp.pop_front();
                check("lookupRespValue", lookupRespValue, r_pop);
            end
            if (cur_init) begin
                check("init_we", ramWE, 1);
                check("init_addr", ramAddr, sweep[5:0]);
                check("init_data", ramWV, 2'b10);
                check("init_grant", lookupGrant, 0);
                sweep++;
            end else begin
                we_exp = (exp_wr.size() != 0) && (!lookupReq || exp_wr.size() >= THRESH);
                check("run_we", ramWE, we_exp);
                check("run_grant", lookupGrant, lookupReq && !we_exp);
                if (we_exp && exp_wr.size() != 0) begin
                    w_pop = exp_wr.pop_front();
                    check("wr_addr", ramAddr, w_pop.idx);
                    check("wr_data", ramWV, w_pop.val);
                end else if (lookupReq) begin
                    check("rd_addr", ramAddr, lookupIndex);
                    exp_rsp.push_back(rsp_model(lookupIndex));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_upd(input logic [5:0] idx, input logic taken, input logic [1:0] prev);
        updateValid     = 1'b1;
        updateIsCondBr  = 1'b1;
        updateIndex     = idx;
        updateTaken     = taken;
        updatePrevValue = prev;
    endtask

    task automatic drain();
        updateValid = 1'b0;
        lookupReq   = 1'b0;
        for (int k = 0; k < 200 && queueCount != 0; k++) tick();
        check("drain_timeout", queueCount, 0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        lookupReq = 1'b0; lookupIndex = '0;
        updateValid = 1'b0; updateIsCondBr = 1'b0; updateIndex = '0;
        updateTaken = 1'b0; updatePrevValue = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_initBusy", initBusy, 1);
        check("rst_ramWE", ramWE, 0);
        check("rst_respValid", lookupRespValid, 0);
        check("rst_respValue", lookupRespValue, 0);
        check("rst_dropped", droppedUpdate, 0);
        check("rst_count", queueCount, 0);
        check("rst_grant", lookupGrant, 0);

        // 40 updates during the sweep: 32 queue, 8 drop; then push while full in RUN.
        tick();
        rst = 1'b0;
        lookupReq = 1'b1;
        for (int i = 0; i < 40; i++) begin
            drive_upd(6'(8 + i), i[0], i[1:0]);
            lookupIndex = 6'($urandom_range(0, N - 1));
            tick();
        end
        updateValid = 1'b0;
        for (int k = 0; k < 100 && initBusy; k++) begin
            lookupIndex = 6'($urandom_range(0, N - 1));
            tick();
        end
        check("init_timeout", initBusy, 0);
        for (int i = 0; i < 20; i++) begin
            drive_upd(6'(8 + (i * 5) % 56), i[1], i[2:1]);
            lookupIndex = 6'($urandom_range(0, N - 1));
            tick();
        end
        updateValid = 1'b0;
        @(negedge clk);
        check("full_count", queueCount, QSIZE);
        check("drop_total", drops_seen, 8);
        tick();
        drain();

        // Single saturating updates on idx 5, plus a non-conditional update that must be ignored.
        drive_upd(6'd5, 1'b1, 2'd3);
        tick();
        updateValid = 1'b0;
        repeat (3) tick();
        check("idx5_taken", mem[5], 2'd3);
        drive_upd(6'd5, 1'b0, 2'd0);
        tick();
        updateIsCondBr = 1'b0;
        updateTaken = 1'b1;
        tick();
        updateValid = 1'b0;
        repeat (3) tick();
        check("idx5_not_taken", mem[5], 2'd0);
        check("noncond_ignored", queueCount, 0);

        // Lookups every cycle with one push per cycle: occupancy settles at the threshold.
        lookupReq = 1'b1;
        for (int i = 0; i < 40; i++) begin
            drive_upd(6'(10 + (i * 7) % 50), i[0], i[2:1]);
            lookupIndex = 6'($urandom_range(0, N - 1));
            tick();
        end
        updateValid = 1'b0;
        @(negedge clk);
        check("threshold_count", queueCount, THRESH);
        tick();
        drain();

        // Two queued writes to idx 7 with a lookup held on idx 7.
        lookupReq = 1'b1;
        lookupIndex = 6'd7;
        drive_upd(6'd7, 1'b1, 2'd0);
        tick();
        drive_upd(6'd7, 1'b1, 2'd2);
        tick();
        updateValid = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        check("idx7_valid", lookupRespValid, 1);
        check("idx7_value", lookupRespValue, IDX7_EXP);
        tick();
        drain();
        check("idx7_final", mem[7], 2'd3);

        // Reset mid-operation: queue and response clear, sweep restarts and lasts N cycles.
        lookupReq = 1'b1;
        lookupIndex = 6'd3;
        drive_upd(6'd9, 1'b1, 2'd1);
        tick();
        updateValid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("midrst_count", queueCount, 0);
        check("midrst_initBusy", initBusy, 1);
        check("midrst_we", ramWE, 0);
        check("midrst_respValid", lookupRespValid, 0);
        lookupReq = 1'b0;
        tick();
        rst = 1'b0;
        n = 0;
        while (initBusy && n < 200) begin
            tick();
            n++;
        end
        check("init_len", n, N);
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pht_access_scheduler.md
Name: pht_access_scheduler

Overview:
- Owns the single read/write port of the PHT RAM.
- Arbitrates between fetch-stage prediction lookups and branch-resolution counter updates.
- Buffers updates in a circular PHT update queue, computes saturating 2-bit counter values, and sweeps the RAM to its initial value after reset.
- Sits between the fetch-stage gshare predictor and the PHT block RAM.

Parameters:
- PHT_ENTRY_NUM, CONF_PHT_ENTRY_NUM: PHT depth; index width PHT_ENTRY_NUM_BIT_WIDTH.
- PHT_QUEUE_SIZE, 32: update queue depth, power of two.
- PHT_DRAIN_THRESHOLD, 24: queue occupancy at or above which a write beats a lookup.
- PHT_INIT_VALUE, 2'b10: counter value written during the init sweep (weakly taken).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- lookupReq  in  1  fetch requests a PHT read this cycle
- lookupIndex  in  PHT_ENTRY_NUM_BIT_WIDTH  read index
- lookupGrant  out  1  read issued this cycle (combinational); when 0, fetch stalls
- lookupRespValid  out  1  registered; lookupGrant delayed by one cycle
- lookupRespValue  out  2  counter for the granted read, one cycle later
- updateValid  in  1  a resolved branch result is presented
- updateIsCondBr  in  1  update applies only when 1
- updateIndex  in  PHT_ENTRY_NUM_BIT_WIDTH  PHT index of the resolved branch
- updateTaken  in  1  execTaken
- updatePrevValue  in  2  phtPrevValue captured at prediction
- ramAddr  out  PHT_ENTRY_NUM_BIT_WIDTH  RAM address
- ramWE  out  1  RAM write enable
- ramWV  out  2  RAM write data
- ramRV  in  2  RAM read data, one cycle after the address
- initBusy  out  1  init sweep in progress
- queueCount  out  PHT_QUEUE_SIZE_BIT_WIDTH+1  occupancy
- droppedUpdate  out  1  registered pulse: an update was lost

Behaviour:
- Reset values: state=INIT, sweep counter 0, queue empty, lookupRespValid=0, lookupRespValue=0, droppedUpdate=0, initBusy=1, ramWE=0. Reset asserted mid-operation aborts everything and restarts INIT.
- FSM states:
  - INIT: each cycle ramWE=1, ramAddr=sweep, ramWV=PHT_INIT_VALUE; sweep++. After writing index PHT_ENTRY_NUM-1 -> RUN, initBusy=0. Duration is exactly PHT_ENTRY_NUM cycles. lookupGrant=0. Queue accepts entries but is not drained.
  - RUN: port arbitration per cycle:
    - Write when queue non-empty and (!lookupReq or queueCount>=PHT_DRAIN_THRESHOLD or queue full).
    - Otherwise, when lookupReq: lookupGrant=1, ramAddr=lookupIndex, ramWE=0.
    - Idle otherwise.
- Enqueue: updateValid && updateIsCondBr. New value = updateTaken ? min(prev+1,3) : max(prev-1,0). Entry stores {index, newValue}.
- Queue is a circular FIFO with head/tail pointers of PHT_QUEUE_SIZE_BIT_WIDTH plus a count. Pointers wrap modulo PHT_QUEUE_SIZE.
- Simultaneous enqueue and dequeue: count unchanged; both pointers advance. Enqueue into an empty queue is written the following cycle at the earliest; there is no same-cycle passthrough.
- Full queue in RUN forces a dequeue the same cycle, so an enqueue at full never drops.
- Full queue in INIT: the update is dropped and droppedUpdate pulses the next cycle.
- Repeated updates to the same index are written in FIFO order; the last one wins.
- lookupRespValue = ramRV, registered when lookupRespValid is set; otherwise it holds.

Optional Feature:
- Macro: RSD_PHT_UPDATE_BYPASS_EN.
- Defined: on a granted lookup, the queue is searched for entries whose index equals lookupIndex. If one matches, the newest match's value is registered and returned as lookupRespValue in place of ramRV. The entry dequeued in the same cycle is included in the search.
- Undefined: no search; responses always come from the RAM, so they may be stale until the queue drains.

Decomposition:
- Additions to FetchUnitTypes:
  - PhtAccessSchedState enum {PHT_SCHED_INIT, PHT_SCHED_RUN}.
  - PhtUpdateQueueEntry {PHT_IndexPath index; PHT_EntryPath value}.
  - PHT_INIT_VALUE.
  - Saturating counter function PhtNextValue(prev, taken).
- Sub-module pht_update_queue: circular FIFO with push/pop/count/full/empty. It exposes its entries and a valid mask for the bypass search.

Test Plan:
- Reset, no traffic: ramWE=1 for exactly PHT_ENTRY_NUM cycles, addresses 0..N-1 with data 2'b10. initBusy falls in the cycle after the last write.
- RUN, update idx=5, taken, prev=3, no lookups: one write idx5 value 3. Then update idx=5, not-taken, prev=0 -> write idx5 value 0.
- Lookup every cycle while pushing one update per cycle: no writes until count reaches 24. From then on, writes win and lookupGrant=0; counts stay bounded and there are no drops.
- Fill to 32 with lookups held high, then push while full: same-cycle dequeue, count stays 32, droppedUpdate=0, FIFO order is preserved across pointer wrap.
- Push 40 updates during INIT: the first 32 are queued, 8 droppedUpdate pulses. After INIT the queued entries drain in order.
- With RSD_PHT_UPDATE_BYPASS_EN defined: queue idx7=1 then idx7=3, lookup idx7 -> lookupRespValue=3 next cycle. With the macro undefined, the same lookup returns the RAM value 2'b10.
